keyboard_reader: RTL and testbench
==================================

// Module: keyboard_reader
// PURPOSE
//  - PS/2 keyboard receiver. Deserialises device-driven PS/2 frames into key events.
//  - Presents the latest key event as the 32-bit keyb_char word.
//  - keyb_char is what the memory mapper returns for CPU reads at I/O address [17:16]=11, [3:2]=00.
//  - Slave end of the keyboard link; host-to-device transmission is not supported.
// PARAMETERS
//  TIMEOUT_CYC  20000  clk cycles without a ps2 falling edge mid-frame before the frame is abandoned
//  FILT_LEN     4      consecutive equal synced samples needed to accept a new ps2_clk level
// PORTS
//  clk        in   1   system clock; all logic on rising edge
//  reset      in   1   synchronous, active-low reset (0 = reset)
//  ps2_clk    in   1   raw PS/2 clock from keyboard, asynchronous
//  ps2_data   in   1   raw PS/2 data from keyboard, asynchronous
//  keyb_char  out  32  {22'b0, brk, ext, code[7:0]} of last completed key event
//  key_valid  out  1   1-cycle pulse in the cycle keyb_char updates
//  frame_err  out  1   1-cycle pulse on parity/start/stop error or timeout
// BEHAVIOUR
//  - Reset (reset==0 at a clk edge):
//    - keyb_char=0, key_valid=0, frame_err=0.
//    - FSM=IDLE; prefix flags cleared; filter state and synchroniser FFs set to 1.
//  - Input conditioning:
//    - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
//    - ps2_clk then goes through the FILT_LEN filter.
//    - A falling edge of the filtered clock = sample strobe; data bit taken from synced ps2_data.
//    - Strobe latency: 2 sync + FILT_LEN cycles after the pin edge.
//  - Frame: 11 bits = start(0), d0..d7 LSB first, odd parity, stop(1).
//  - FSM states: IDLE, DATA, PARITY, STOP.
//    - IDLE: strobe with data=0 -> DATA, bit count=0. Strobe with data=1 -> ignored, stay IDLE.
//    - DATA: each strobe shifts a bit in (LSB first); after the 8th bit -> PARITY.
//    - PARITY: strobe -> store parity-ok = (^byte ^ bit)==1 -> STOP.
//    - STOP: strobe -> IDLE. If bit==1 and parity-ok: byte accepted. Otherwise frame_err pulses, byte dropped.
//  - Timeout: idle counter clears on every strobe and counts while FSM != IDLE.
//    - Reaching TIMEOUT_CYC -> frame_err pulse, FSM=IDLE, partial byte discarded, prefix flags kept.
//  - Accepted byte decode, registered; takes effect the cycle after the STOP strobe:
//    - 8'hE0: ext_flag=1; keyb_char unchanged; no key_valid.
//    - 8'hF0: brk_flag=1; keyb_char unchanged; no key_valid.
//    - Any other byte b:
//      - keyb_char <= {22'b0, brk_flag, ext_flag, b}; key_valid=1 for one cycle.
//      - Both flags cleared in the same cycle.
//  - keyb_char holds until the next event; CPU reads have no side effects (no read-clear).
//  - Bytes arriving back to back: each produces its own key_valid; no buffering beyond one word.
//  - Reset asserted mid-frame: frame abandoned, no key_valid or frame_err, outputs = reset values.
//  - frame_err and key_valid are never asserted in the same cycle.
// TESTING
//  1. Frame for 8'h1C (A press, parity 0) -> key_valid pulse; keyb_char=32'h0000001C.
//  2. Frames E0 then 75 -> one key_valid, after the second frame only; keyb_char=32'h00000175.
//  3. Frames F0 then 1C -> keyb_char=32'h0000021C. Then E0,F0,75 -> keyb_char=32'h00000375.
//  4. Frame 8'h1C with parity bit=1 -> frame_err pulse, no key_valid, keyb_char keeps prior value.
//     Repeat with stop bit=0 -> same result.
//  5. Send start + 4 data bits, then hold ps2_clk high for TIMEOUT_CYC+10 cycles:
//     - frame_err pulses once, FSM returns to IDLE.
//     - A following valid 8'h29 frame gives keyb_char=32'h00000029.
//  6. reset=0 for 1 cycle mid-DATA -> keyb_char=0 and no pulses.
//     A following 8'h1C frame decodes correctly.
//     1-cycle ps2_clk glitch (< FILT_LEN) in IDLE -> no strobe.

Source files
------------

// File: rtl/keyboard_reader.sv
// PS/2 keyboard receiver: conditions the raw PS/2 lines, deserialises 11-bit frames
// and folds E0/F0 prefixes into a 32-bit key event word.
module keyboard_reader #(
  parameter int TIMEOUT_CYC = 20000,
  parameter int FILT_LEN    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [31:0] keyb_char,
  output logic        key_valid,
  output logic        frame_err
);

  localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  // Two-stage synchronisers for both PS/2 lines
  logic [1:0] clk_sync_reg;
  logic [1:0] data_sync_reg;
  logic       clk_synced;
  logic       data_synced;

  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_sync_reg  <= 2'b11;
      data_sync_reg <= 2'b11;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
      data_sync_reg <= {data_sync_reg[0], ps2_data};
    end
  end

  assign clk_synced  = clk_sync_reg[1];
  assign data_synced = data_sync_reg[1];

  // Glitch filter: a new clock level is accepted after FILT_LEN consecutive samples
  logic           filt_level_reg;
  logic [FCW-1:0] filt_cnt_reg;
  logic           strobe_reg;
  logic           strobe_bit_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      filt_level_reg <= 1'b1;
      filt_cnt_reg   <= '0;
      strobe_reg     <= 1'b0;
      strobe_bit_reg <= 1'b1;
    end else begin
      strobe_reg <= 1'b0;
      if (clk_synced == filt_level_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_cnt_reg == FCW'(FILT_LEN - 1)) begin
        filt_level_reg <= clk_synced;
        filt_cnt_reg   <= '0;
        strobe_reg     <= ~clk_synced;
        strobe_bit_reg <= data_synced;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + 1'b1;
      end
    end
  end

  // Frame deserialiser with mid-frame timeout
  logic [1:0]     state_reg;
  logic [2:0]     bit_cnt_reg;
  logic [7:0]     shift_reg;
  logic           par_ok_reg;
  logic [TCW-1:0] to_cnt_reg;
  logic           byte_valid_reg;
  logic [7:0]     byte_reg;
  logic           err_stage_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      par_ok_reg     <= 1'b0;
      to_cnt_reg     <= '0;
      byte_valid_reg <= 1'b0;
      byte_reg       <= '0;
      err_stage_reg  <= 1'b0;
    end else begin
      byte_valid_reg <= 1'b0;
      err_stage_reg  <= 1'b0;
      if (strobe_reg) begin
        to_cnt_reg <= '0;
        case (state_reg)
          ST_IDLE: begin
            if (!strobe_bit_reg) begin
              state_reg   <= ST_DATA;
              bit_cnt_reg <= '0;
            end
          end
          ST_DATA: begin
            shift_reg   <= {strobe_bit_reg, shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == 3'd7) begin
              state_reg <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            par_ok_reg <= (^shift_reg) ^ strobe_bit_reg;
            state_reg  <= ST_STOP;
          end
          default: begin
            state_reg <= ST_IDLE;
            if (strobe_bit_reg && par_ok_reg) begin
              byte_valid_reg <= 1'b1;
              byte_reg       <= shift_reg;
            end else begin
              err_stage_reg <= 1'b1;
            end
          end
        endcase
      end else if (state_reg != ST_IDLE) begin
        if (to_cnt_reg == TCW'(TIMEOUT_CYC - 1)) begin
          err_stage_reg <= 1'b1;
          state_reg     <= ST_IDLE;
          to_cnt_reg    <= '0;
        end else begin
          to_cnt_reg <= to_cnt_reg + 1'b1;
        end
      end else begin
        to_cnt_reg <= '0;
      end
    end
  end

  // Prefix folding; byte_valid and err_stage are exclusive, so the pulses never overlap
  logic       ext_flag_reg;
  logic       brk_flag_reg;
  logic [9:0] event_reg;
  logic       key_valid_reg;
  logic       frame_err_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ext_flag_reg  <= 1'b0;
      brk_flag_reg  <= 1'b0;
      event_reg     <= '0;
      key_valid_reg <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      key_valid_reg <= 1'b0;
      frame_err_reg <= err_stage_reg;
      if (byte_valid_reg) begin
        if (byte_reg == CODE_EXT) begin
          ext_flag_reg <= 1'b1;
        end else if (byte_reg == CODE_BRK) begin
          brk_flag_reg <= 1'b1;
        end else begin
          event_reg     <= {brk_flag_reg, ext_flag_reg, byte_reg};
          key_valid_reg <= 1'b1;
          ext_flag_reg  <= 1'b0;
          brk_flag_reg  <= 1'b0;
        end
      end
    end
  end

  assign keyb_char = {22'b0, event_reg};
  assign key_valid = key_valid_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_keyboard_reader.sv
// Directed bench for keyboard_reader: drives PS/2 frames and checks pulse counts and keyb_char.
module tb_keyboard_reader;

  localparam int HALF    = 16;
  localparam int TIMEOUT = 20000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [31:0] keyb_char;
  logic        key_valid;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int kv_total = 0;
  int fe_total = 0;
  int both_total = 0;

  always #5 clk = ~clk;

  keyboard_reader #(.TIMEOUT_CYC(TIMEOUT), .FILT_LEN(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keyb_char (keyb_char),
    .key_valid (key_valid),
    .frame_err (frame_err)
  );

  // Pulse counters sampled away from the active edge
  always @(negedge clk) begin
    if (key_valid) kv_total++;
    if (frame_err) fe_total++;
    if (key_valid && frame_err) both_total++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic flip_par,
                                           input logic stop);
    return {stop, (~^b) ^ flip_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] frame, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = frame[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_and_check(input string tag, input logic [7:0] b, input logic flip_par,
                                input logic stop, input int exp_kv, input int exp_fe,
                                input logic [31:0] exp_char);
    int kv0;
    int fe0;
    kv0 = kv_total;
    fe0 = fe_total;
    send_bits(mk_frame(b, flip_par, stop), 11);
    ps2_data = 1'b1;
    wait_cyc(2 * HALF);
    $display("frame %s byte=%h keyb_char=%h key_valid_pulses=%0d frame_err_pulses=%0d",
             tag, b, keyb_char, kv_total - kv0, fe_total - fe0);
    check({tag, "_kv"}, 32'(kv_total - kv0), 32'(exp_kv));
    check({tag, "_fe"}, 32'(fe_total - fe0), 32'(exp_fe));
    check({tag, "_char"}, keyb_char, exp_char);
  endtask

  initial begin
    int kv0;
    int fe0;

    reset = 1'b0;
    wait_cyc(3);
    check("rst_char", keyb_char, 32'h0);
    check("rst_kv", {31'b0, key_valid}, 32'h0);
    check("rst_fe", {31'b0, frame_err}, 32'h0);
    reset = 1'b1;
    wait_cyc(10);

    send_and_check("a_press", 8'h1C, 1'b0, 1'b1, 1, 0, 32'h0000001C);
    send_and_check("ext_pre", 8'hE0, 1'b0, 1'b1, 0, 0, 32'h0000001C);
    send_and_check("ext_75", 8'h75, 1'b0, 1'b1, 1, 0, 32'h00000175);
    send_and_check("brk_pre", 8'hF0, 1'b0, 1'b1, 0, 0, 32'h00000175);
    send_and_check("brk_1c", 8'h1C, 1'b0, 1'b1, 1, 0, 32'h0000021C);
    send_and_check("eb_e0", 8'hE0, 1'b0, 1'b1, 0, 0, 32'h0000021C);
    send_and_check("eb_f0", 8'hF0, 1'b0, 1'b1, 0, 0, 32'h0000021C);
    send_and_check("eb_75", 8'h75, 1'b0, 1'b1, 1, 0, 32'h00000375);
    send_and_check("bad_par", 8'h1C, 1'b1, 1'b1, 0, 1, 32'h00000375);
    send_and_check("bad_stop", 8'h1C, 1'b0, 1'b0, 0, 1, 32'h00000375);

    // Partial frame then silence: expect exactly one timeout error
    kv0 = kv_total;
    fe0 = fe_total;
    send_bits(mk_frame(8'h5A, 1'b0, 1'b1), 5);
    ps2_data = 1'b1;
    wait_cyc(TIMEOUT + 60);
    $display("timeout keyb_char=%h frame_err_pulses=%0d", keyb_char, fe_total - fe0);
    check("to_fe", 32'(fe_total - fe0), 32'd1);
    check("to_kv", 32'(kv_total - kv0), 32'd0);
    check("to_char", keyb_char, 32'h00000375);
    send_and_check("after_to", 8'h29, 1'b0, 1'b1, 1, 0, 32'h00000029);

    // One-cycle reset in the middle of the data bits
    kv0 = kv_total;
    fe0 = fe_total;
    send_bits(mk_frame(8'h5A, 1'b0, 1'b1), 4);
    ps2_data = 1'b1;
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(1);
    check("mid_rst_char", keyb_char, 32'h0);
    reset = 1'b1;
    wait_cyc(4 * HALF);
    $display("mid_reset keyb_char=%h pulses kv=%0d fe=%0d", keyb_char, kv_total - kv0,
             fe_total - fe0);
    check("mid_rst_kv", 32'(kv_total - kv0), 32'd0);
    check("mid_rst_fe", 32'(fe_total - fe0), 32'd0);
    send_and_check("post_rst", 8'h1C, 1'b0, 1'b1, 1, 0, 32'h0000001C);

    // One-cycle clock glitch with data low must not start a frame
    fe0 = fe_total;
    ps2_data = 1'b0;
    wait_cyc(1);
    ps2_clk = 1'b0;
    wait_cyc(1);
    ps2_clk = 1'b1;
    wait_cyc(2);
    ps2_data = 1'b1;
    wait_cyc(4 * HALF);
    $display("glitch frame_err_pulses=%0d", fe_total - fe0);
    check("glitch_fe", 32'(fe_total - fe0), 32'd0);
    send_and_check("post_glitch", 8'h4D, 1'b0, 1'b1, 1, 0, 32'h0000004D);

    check("no_overlap", 32'(both_total), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
